// File: rtl/intc.sv
// intc: level-sensitive interrupt controller with per-source enable, 2-bit
// priority and a claim/complete gateway per source, exposed on sys_bus.
module intc #(
    parameter int N_SRC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             intc_we,
    input  logic             intc_re,
    input  logic [31:0]      intc_adr,
    input  logic [31:0]      intc_wdata,
    output logic [31:0]      intc_rdata,
    output logic             int_sig
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PENDING    = 2'd1,
        IN_SERVICE = 2'd2
    } gw_state_t;

    localparam logic [3:0] ADR_ENABLE = 4'h0;
    localparam logic [3:0] ADR_STATUS = 4'h4;
    localparam logic [3:0] ADR_PRIO   = 4'h8;
    localparam logic [3:0] ADR_CLAIM  = 4'hC;

    gw_state_t          state      [N_SRC];
    gw_state_t          state_next [N_SRC];
    logic [N_SRC-1:0]   enable;
    logic [2*N_SRC-1:0] prio;
    logic [N_SRC-1:0]   pending;
    logic [N_SRC-1:0]   in_service;
    logic [N_SRC-1:0]   eligible;
    logic [4:0]         win_id;
    logic [1:0]         win_prio;
    logic [3:0]         adr;
    logic               do_claim;
    logic               do_complete;
    logic               unused_bits;

    assign adr         = intc_adr[3:0];
    // A simultaneous write takes the cycle, so the claim side effect is dropped.
    assign do_claim    = intc_re & ~intc_we & (adr == ADR_CLAIM);
    assign do_complete = intc_we & (adr == ADR_CLAIM);
    // Address bits above the 16-byte window and spare data bits are ignored.
    assign unused_bits = ^{intc_adr[31:4], intc_wdata};

    // Per-source status flags derived from gateway state and configuration.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pending    = '0;
        in_service = '0;
        eligible   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            pending[i]    = (state[i] == PENDING);
            in_service[i] = (state[i] == IN_SERVICE);
            eligible[i]   = pending[i] & enable[i] & (prio[2*i +: 2] != 2'd0);
        end
    end

    // Winner: highest priority among eligible sources; strict compare keeps the lowest index on ties.
    always_comb begin
        win_id   = '0;
        win_prio = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (eligible[i] && (prio[2*i +: 2] > win_prio)) begin
                win_prio = prio[2*i +: 2];
                win_id   = 5'(i + 1);
            end
        end
    end

    // Gateway next state; a complete in IN_SERVICE beats a same-edge line sample.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            state_next[i] = state[i];
            case (state[i])
                IDLE:       if (irq_src[i]) state_next[i] = PENDING;
                PENDING:    if (do_claim && (win_id == 5'(i + 1))) state_next[i] = IN_SERVICE;
                IN_SERVICE: if (do_complete && (intc_wdata[4:0] == 5'(i + 1))) state_next[i] = IDLE;
                default:    state_next[i] = IDLE;
            endcase
        end
    end

    // Gateway state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                state[i] <= IDLE;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            for (int i = 0; i < N_SRC; i++) begin
                state[i] <= state_next[i];
            end
        end
    end

    // ENABLE and PRIORITY configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable <= '0;
            prio   <= '0;
        end else if (intc_we) begin
            if (adr == ADR_ENABLE) enable <= intc_wdata[N_SRC-1:0];
            if (adr == ADR_PRIO)   prio   <= intc_wdata[2*N_SRC-1:0];
        end
    end

    // Registered interrupt request to the core.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_sig <= 1'b0;
        end else begin
            int_sig <= |eligible;
        end
    end

    // Combinational register read mux.
    always_comb begin
        intc_rdata = '0;
        case (adr)
            ADR_ENABLE: intc_rdata = 32'(enable);
            ADR_STATUS: intc_rdata = 32'(pending) | (32'(in_service) << 16);
            ADR_PRIO:   intc_rdata = 32'(prio);
            ADR_CLAIM:  intc_rdata = 32'(win_id);
            default:    intc_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_intc.sv
// tb_intc: directed self-checking bench for the intc interrupt controller.
module tb_intc;

    localparam int N_SRC = 4;

    logic             clk;
    logic             rst;
    logic [N_SRC-1:0] irq_src;
    logic             intc_we;
    logic             intc_re;
    logic [31:0]      intc_adr;
    logic [31:0]      intc_wdata;
    logic [31:0]      intc_rdata;
    logic             int_sig;

    int n_checks;
    int n_errors;
    logic [31:0] val;

    intc #(.N_SRC(N_SRC)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_src    (irq_src),
        .intc_we    (intc_we),
        .intc_re    (intc_re),
        .intc_adr   (intc_adr),
        .intc_wdata (intc_wdata),
        .intc_rdata (intc_rdata),
        .int_sig    (int_sig)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] data);
        intc_adr   = adr;
        intc_wdata = data;
        intc_we    = 1'b1;
        tick();
        intc_we    = 1'b0;
    endtask

    task automatic rd(input logic [31:0] adr, output logic [31:0] data);
        intc_adr = adr;
        #1;
        data = intc_rdata;
    endtask

    // Read CLAIM with the read strobe held across one edge.
    task automatic claim(output logic [31:0] id);
        intc_adr = 32'hC;
        intc_re  = 1'b1;
        #1;
        id = intc_rdata;
        tick();
        intc_re  = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        irq_src    = '0;
        intc_we    = 1'b0;
        intc_re    = 1'b0;
        intc_adr   = '0;
        intc_wdata = '0;
        tick();
        tick();
        rst = 1'b0;

        // Idle after reset.
        check("rst_int_sig", 32'(int_sig), 32'h0);
        rd(32'h0, val); check("rst_enable", val, 32'h0);
        rd(32'h4, val); check("rst_status", val, 32'h0);
        rd(32'h8, val); check("rst_prio",   val, 32'h0);
        rd(32'hC, val); check("rst_claim",  val, 32'h0);

        // Timer path on source 0.
        wr(32'h0, 32'h1);
        wr(32'h8, 32'h1);
        irq_src = 4'b0001;
        tick();
        irq_src = 4'b0000;
        rd(32'h4, val); check("tmr_pending", val, 32'h1);
        check("tmr_int_sig_lat1", 32'(int_sig), 32'h0);
        tick();
        check("tmr_int_sig_lat2", 32'(int_sig), 32'h1);
        claim(val); check("tmr_claim_id", val, 32'h1);
        rd(32'h4, val); check("tmr_in_service", val, 32'h0001_0000);
        tick();
        check("tmr_int_sig_drop", 32'(int_sig), 32'h0);
        wr(32'hC, 32'h1);
        rd(32'h4, val); check("tmr_completed", val, 32'h0);

        // Arbitration between sources 1 and 3.
        wr(32'h0, 32'hF);
        wr(32'h8, 32'h88);
        irq_src = 4'b1010;
        tick();
        irq_src = 4'b0000;
        rd(32'h4, val); check("arb_pending", val, 32'hA);
        rd(32'hC, val); check("arb_tie_low_index", val, 32'h2);
        wr(32'h8, 32'hC8);
        rd(32'hC, val); check("arb_high_prio", val, 32'h4);
        wr(32'h8, 32'hC0);
        rd(32'hC, val); check("arb_prio0_skip", val, 32'h4);
        claim(val); check("arb_claim4", val, 32'h4);
        rd(32'h4, val); check("arb_status_claim4", val, 32'h0008_0002);
        claim(val); check("arb_claim_none", val, 32'h0);
        rd(32'h4, val); check("arb_status_unchanged", val, 32'h0008_0002);
        wr(32'hC, 32'h4);
        rd(32'h4, val); check("arb_complete4", val, 32'h2);

        // Masking: source 1 pending with nonzero priority but disabled.
        wr(32'h0, 32'h0);
        wr(32'h8, 32'h4);
        tick();
        tick();
        check("mask_int_sig", 32'(int_sig), 32'h0);
        claim(val); check("mask_claim", val, 32'h0);
        rd(32'h4, val); check("mask_status", val, 32'h2);

        // Bad completes leave the in-service source alone.
        wr(32'h0, 32'h2);
        claim(val); check("bad_claim2", val, 32'h2);
        rd(32'h4, val); check("bad_in_service", val, 32'h0002_0000);
        wr(32'hC, 32'h0);
        rd(32'h4, val); check("bad_id0", val, 32'h0002_0000);
        wr(32'hC, 32'h7);
        wr(32'hC, 32'h5);
        rd(32'h4, val); check("bad_id_range", val, 32'h0002_0000);
        wr(32'hC, 32'h3);
        rd(32'h4, val); check("bad_not_in_service", val, 32'h0002_0000);
        wr(32'hC, 32'h2);
        rd(32'h4, val); check("good_complete2", val, 32'h0);

        // Level re-entry on source 2 with the line held high.
        wr(32'h0, 32'h4);
        wr(32'h8, 32'h10);
        irq_src = 4'b0100;
        tick();
        rd(32'h4, val); check("lvl_pending", val, 32'h4);
        tick();
        check("lvl_int_sig", 32'(int_sig), 32'h1);
        claim(val); check("lvl_claim3", val, 32'h3);
        rd(32'h4, val); check("lvl_in_service", val, 32'h0004_0000);
        wr(32'hC, 32'h3);
        rd(32'h4, val); check("lvl_idle_after_complete", val, 32'h0);
        check("lvl_int_sig_k", 32'(int_sig), 32'h0);
        tick();
        rd(32'h4, val); check("lvl_repending_k1", val, 32'h4);
        check("lvl_int_sig_k1", 32'(int_sig), 32'h0);
        tick();
        check("lvl_int_sig_k2", 32'(int_sig), 32'h1);
        irq_src = 4'b0000;
        claim(val); check("lvl_reclaim3", val, 32'h3);

        // Bus collision: write and read strobes together at CLAIM.
        wr(32'h0, 32'h5);
        wr(32'h8, 32'h11);
        irq_src = 4'b0001;
        tick();
        irq_src = 4'b0000;
        rd(32'h4, val); check("col_setup", val, 32'h0004_0001);
        intc_adr   = 32'hC;
        intc_wdata = 32'h3;
        intc_we    = 1'b1;
        intc_re    = 1'b1;
        #1;
        check("col_winner", intc_rdata, 32'h1);
        tick();
        intc_we = 1'b0;
        intc_re = 1'b0;
        rd(32'h4, val); check("col_complete_no_claim", val, 32'h1);
        check("col_int_sig", 32'(int_sig), 32'h1);

        // Asynchronous reset with source 0 pending.
        rst = 1'b1;
        #1;
        check("arst_int_sig", 32'(int_sig), 32'h0);
        rd(32'h4, val); check("arst_status", val, 32'h0);
        rd(32'h0, val); check("arst_enable", val, 32'h0);
        rd(32'h8, val); check("arst_prio",   val, 32'h0);
        rd(32'hC, val); check("arst_claim",  val, 32'h0);
        rst = 1'b0;
        tick();
        rd(32'h4, val); check("arst_no_reentry", val, 32'h0);
        check("arst_int_sig_after", 32'(int_sig), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
